// File: rtl/fetch_pipe.sv
// fetch_pipe: PC register, instruction-memory addressing and the stage 1-4
// instruction pipe registers of the 4-stage CPU front end.
// Stage 1 is combinational off the synchronous imem; stages 2-4 are flops.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_pipe #(
  parameter int unsigned      PC_W     = 16,
  parameter logic [PC_W-1:0]  RESET_PC = '0,
  parameter logic [15:0]      NOP_INST = 16'h001F
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic [PC_W-1:0] imem_addr,
  input  logic [15:0]     imem_rdata,
  input  logic            pc_enable,
  input  logic            PCSrc,
  input  logic            hold_in_decode_state,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
  output logic [15:0]     inst_ipipe [1:4],
  output logic [4:0]      opcode [1:4],
  output logic [PC_W-1:0] pc_ipipe [1:4],
  output logic            valid_ipipe [1:4]
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_cycles,
  output logic [31:0]     perf_retired,
  output logic [31:0]     perf_stall,
  output logic [31:0]     perf_flush
`endif
);

  typedef enum logic [1:0] {StBoot, StRun, StRedir} fetch_state_e;

  fetch_state_e    state_q, state_d;
  logic            fetch_valid;
  logic [PC_W-1:0] pc_q, pc_d;

  logic [15:0]     inst_q  [2:4];
  logic [15:0]     inst_d  [2:4];
  logic [PC_W-1:0] spc_q   [2:4];
  logic [PC_W-1:0] spc_d   [2:4];
  logic            valid_q [2:4];
  logic            valid_d [2:4];

  logic [15:0]     s1_inst;
  logic [PC_W-1:0] s1_pc;

  // PCSrc is informational only; the branch target arrives with br_taken.
  logic unused_pcsrc;
  assign unused_pcsrc = PCSrc;

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= StBoot;
    else          state_q <= state_d;
  end

  // FSM next state: one bubble cycle after reset and after each redirect
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StBoot:  state_d = StRun;
      StRun:   state_d = br_taken ? StRedir : StRun;
      StRedir: state_d = br_taken ? StRedir : StRun;
      default: state_d = StBoot;
    endcase
  end

  // FSM output: imem data is only meaningful once the current PC was addressed
  always_comb begin
    fetch_valid = (state_q == StRun);
  end

  // Next PC; PC holds while not fetching so the bubbled fetch is re-issued
  always_comb begin
    if (br_taken) begin
      pc_d = br_target;
    end else if (!fetch_valid || hold_in_decode_state || !pc_enable) begin
      pc_d = pc_q;
    end else begin
      pc_d = pc_q + PC_W'(2);
    end
  end

  assign imem_addr = pc_d;

  // Stage 1 view of the word returned for the current PC
  always_comb begin
    s1_inst = fetch_valid ? imem_rdata : NOP_INST;
    s1_pc   = fetch_valid ? pc_q : '0;
  end

  // Pipe advance: branch flush > decode hold > PC stall > full shift
  always_comb begin
    inst_d  = inst_q;
    spc_d   = spc_q;
    valid_d = valid_q;
    inst_d[4]  = inst_q[3];
    spc_d[4]   = spc_q[3];
    valid_d[4] = valid_q[3];
    if (br_taken) begin
      inst_d[2] = NOP_INST; spc_d[2] = '0; valid_d[2] = 1'b0;
      inst_d[3] = NOP_INST; spc_d[3] = '0; valid_d[3] = 1'b0;
    end else if (hold_in_decode_state) begin
      inst_d[3] = NOP_INST; spc_d[3] = '0; valid_d[3] = 1'b0;
    end else if (!pc_enable) begin
      inst_d[2] = NOP_INST; spc_d[2] = '0; valid_d[2] = 1'b0;
      inst_d[3] = inst_q[2]; spc_d[3] = spc_q[2]; valid_d[3] = valid_q[2];
    end else begin
      inst_d[2] = s1_inst; spc_d[2] = s1_pc; valid_d[2] = fetch_valid;
      inst_d[3] = inst_q[2]; spc_d[3] = spc_q[2]; valid_d[3] = valid_q[2];
    end
  end

  // PC and stage 2-4 registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q <= RESET_PC;
      for (int i = 2; i <= 4; i++) begin
        inst_q[i]  <= NOP_INST;
        spc_q[i]   <= '0;
        valid_q[i] <= 1'b0;
      end
    end else begin
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      spc_q   <= spc_d;
      valid_q <= valid_d;
    end
  end

  // Per-stage output arrays
  always_comb begin
    inst_ipipe[1]  = s1_inst;
    pc_ipipe[1]    = s1_pc;
    valid_ipipe[1] = fetch_valid;
    opcode[1]      = s1_inst[4:0];
    for (int i = 2; i <= 4; i++) begin
      inst_ipipe[i]  = inst_q[i];
      pc_ipipe[i]    = spc_q[i];
      valid_ipipe[i] = valid_q[i];
      opcode[i]      = inst_q[i][4:0];
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] cyc_q, cyc_d, ret_q, ret_d, stall_q, stall_d, flush_q, flush_d;

  function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input logic inc);
    return (inc && (cnt != 32'hFFFF_FFFF)) ? cnt + 32'd1 : cnt;
  endfunction

  // Saturating event counters; a branch cycle counts as flush, never as stall
  always_comb begin
    cyc_d   = sat_inc(cyc_q, 1'b1);
    ret_d   = sat_inc(ret_q, valid_q[4]);
    stall_d = sat_inc(stall_q, (hold_in_decode_state || !pc_enable) && !br_taken);
    flush_d = sat_inc(flush_q, br_taken);
  end

  // Counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cyc_q   <= '0;
      ret_q   <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      cyc_q   <= cyc_d;
      ret_q   <= ret_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign perf_cycles  = cyc_q;
  assign perf_retired = ret_q;
  assign perf_stall   = stall_q;
  assign perf_flush   = flush_q;
`endif

endmodule
